// File: rtl/inst_fetch.sv
// Instruction fetch front end: fetch PC, single-outstanding imem request,
// small instruction FIFO toward decode, and branch redirect with flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               inst_valid_q, inst_valid_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;
  logic [31:0]        mem_data_q [FIFO_DEPTH];
  logic [31:0]        mem_pc_q   [FIFO_DEPTH];

  logic               hs;
  logic               push;
  logic               pop;
  logic [31:0]        head_data;
  logic [31:0]        head_pc;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Next-state, FIFO bookkeeping and registered output values
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    head_data  = 32'h0;
    head_pc    = 32'h0;

    hs   = req_valid_q & imem_req_ready;
    pop  = inst_valid_q & inst_ready;
    push = (state_q == WAIT) & imem_resp_valid & ~redirect_valid;

    case (state_q)
      IDLE: begin
        if (hs) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: if (imem_resp_valid) state_d = IDLE;
      DROP: if (imem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Redirect wins: an outstanding request becomes stale, buffer is flushed
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (state_d == WAIT) state_d = DROP;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // The entry being written this cycle may become the head immediately
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_data = imem_resp_data;
      head_pc   = req_pc_q;
    end else begin
      head_data = mem_data_q[rd_ptr_d];
      head_pc   = mem_pc_q[rd_ptr_d];
    end

    req_valid_d  = (state_d == IDLE) && (cnt_d < CNT_W'(FIFO_DEPTH));
    inst_valid_d = (cnt_d != '0);
    inst_d       = inst_valid_d ? head_data : inst_q;
    inst_pc_d    = inst_valid_d ? head_pc   : inst_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      req_valid_q  <= 1'b0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_data_q[wr_ptr_q] <= imem_resp_data;
      mem_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// share stimulus; sel picks which one the checks observe.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        rv0, rv1, iv0, iv1;
  logic [31:0] ra0, ra1, i0, i1, ip0, ip1;

  logic        sel;
  logic        mem_auto;
  int          errors = 0;
  int          checks = 0;

  wire         req_v = sel ? rv1 : rv0;
  wire  [31:0] req_a = sel ? ra1 : ra0;
  wire         ivld  = sel ? iv1 : iv0;
  wire  [31:0] idata = sel ? i1  : i0;
  wire  [31:0] ipc   = sel ? ip1 : ip0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut0 (
    .clk(clk), .reset(reset),
    .imem_req_valid(rv0), .imem_req_ready(imem_req_ready), .imem_req_addr(ra0),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(iv0), .inst_ready(inst_ready), .inst(i0), .inst_pc(ip0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .reset(reset),
    .imem_req_valid(rv1), .imem_req_ready(imem_req_ready), .imem_req_addr(ra1),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(iv1), .inst_ready(inst_ready), .inst(i1), .inst_pc(ip1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // One clock; memory answers an accepted request in the following cycle
  // with data = addr ^ 32'h1234_5678 when mem_auto is set.
  task automatic step();
    logic        hs;
    logic [31:0] hs_addr;
    hs      = req_v && imem_req_ready && !reset;
    hs_addr = req_a;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (mem_auto) begin
      imem_resp_valid = hs;
      imem_resp_data  = hs ? (hs_addr ^ 32'h1234_5678) : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    mem_auto        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b1; mem_auto = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b want=0", req_v); end
    checks++; if (req_a !== 32'h0) begin errors++; $display("FAIL rst_req_addr got=%h want=0", req_a); end
    checks++; if (ivld !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got=%b want=0", ivld); end
    checks++; if (idata !== 32'h0 || ipc !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h/%h want=0/0", idata, ipc); end
    reset = 1'b0;
    step();
    checks++; if (req_v !== 1'b1 || req_a !== 32'h0) begin errors++; $display("FAIL rst_first_req got=%b/%h want=1/0", req_v, req_a); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; mem_auto = 1'b1;
    step();
    checks++; if (req_v !== 1'b0 || ivld !== 1'b0) begin errors++; $display("FAIL stream_wait got=%b/%b want=0/0", req_v, ivld); end
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h0 || idata !== 32'h1234_5678) begin errors++; $display("FAIL stream_i0 got=%b/%h/%h want=1/0/12345678", ivld, ipc, idata); end
    checks++; if (req_v !== 1'b1 || req_a !== 32'h4) begin errors++; $display("FAIL stream_req4 got=%b/%h want=1/4", req_v, req_a); end
    step();
    checks++; if (ivld !== 1'b0) begin errors++; $display("FAIL stream_gap got=%b want=0", ivld); end
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h4 || idata !== 32'h1234_567C) begin errors++; $display("FAIL stream_i4 got=%b/%h/%h want=1/4/1234567c", ivld, ipc, idata); end
    step();
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h8 || idata !== 32'h1234_5670) begin errors++; $display("FAIL stream_i8 got=%b/%h/%h want=1/8/12345670", ivld, ipc, idata); end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b1;
    repeat (4) step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h0 || req_v !== 1'b0) begin errors++; $display("FAIL bp_full got=%b/%h/%b want=1/0/0", ivld, ipc, req_v); end
    step();
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h0 || req_v !== 1'b0) begin errors++; $display("FAIL bp_hold got=%b/%h/%b want=1/0/0", ivld, ipc, req_v); end
    inst_ready = 1'b1;
    step();
    checks++; if (ipc !== 32'h4 || idata !== 32'h1234_567C || req_v !== 1'b1 || req_a !== 32'h8) begin errors++; $display("FAIL bp_pop0 got=%h/%h/%b/%h want=4/1234567c/1/8", ipc, idata, req_v, req_a); end
    step();
    checks++; if (ivld !== 1'b0) begin errors++; $display("FAIL bp_pop4 got=%b want=0", ivld); end
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h8) begin errors++; $display("FAIL bp_resume got=%b/%h want=1/8", ivld, ipc); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b1;
    repeat (4) step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0; mem_auto = 1'b0;
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h4 || req_v !== 1'b0) begin errors++; $display("FAIL rw_setup got=%b/%h/%b want=1/4/0", ivld, ipc, req_v); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    checks++; if (ivld !== 1'b0 || req_v !== 1'b0 || req_a !== 32'h100) begin errors++; $display("FAIL rw_drop got=%b/%b/%h want=0/0/100", ivld, req_v, req_a); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ivld !== 1'b0 || req_v !== 1'b1 || req_a !== 32'h100) begin errors++; $display("FAIL rw_reissue got=%b/%b/%h want=0/1/100", ivld, req_v, req_a); end
    mem_auto = 1'b1; inst_ready = 1'b1;
    step();
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h100 || idata !== 32'h1234_5778) begin errors++; $display("FAIL rw_target got=%b/%h/%h want=1/100/12345778", ivld, ipc, idata); end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; mem_auto = 1'b0;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ivld !== 1'b0 || req_v !== 1'b1 || req_a !== 32'h200) begin errors++; $display("FAIL rr_same got=%b/%b/%h want=0/1/200", ivld, req_v, req_a); end
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    checks++; if (req_v !== 1'b0 || req_a !== 32'h300) begin errors++; $display("FAIL rr_hs_drop got=%b/%h want=0/300", req_v, req_a); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0200;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ivld !== 1'b0 || req_v !== 1'b1 || req_a !== 32'h300) begin errors++; $display("FAIL rr_stale got=%b/%b/%h want=0/1/300", ivld, req_v, req_a); end
    mem_auto = 1'b1;
    step();
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h300 || idata !== 32'h1234_5578) begin errors++; $display("FAIL rr_target got=%b/%h/%h want=1/300/12345578", ivld, ipc, idata); end
  endtask

  task automatic test_stall();
    do_reset();
    imem_req_ready = 1'b0; inst_ready = 1'b1; mem_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (req_v !== 1'b1 || req_a !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d] got=%b/%h want=1/0", i, req_v, req_a); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    checks++; if (req_v !== 1'b1 || req_a !== 32'h40) begin errors++; $display("FAIL stall_redirect got=%b/%h want=1/40", req_v, req_a); end
    imem_req_ready = 1'b1;
    step();
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'h40 || idata !== 32'h1234_5638) begin errors++; $display("FAIL stall_target got=%b/%h/%h want=1/40/12345638", ivld, ipc, idata); end
  endtask

  task automatic test_wrap_late_resp();
    sel = 1'b1;
    do_reset();
    checks++; if (req_v !== 1'b1 || req_a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got=%b/%h want=1/fffffffc", req_v, req_a); end
    imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b1;
    step();
    step();
    checks++; if (ivld !== 1'b1 || ipc !== 32'hFFFF_FFFC || idata !== 32'hEDCB_A984) begin errors++; $display("FAIL wrap_inst got=%b/%h/%h want=1/fffffffc/edcba984", ivld, ipc, idata); end
    checks++; if (req_v !== 1'b1 || req_a !== 32'h0) begin errors++; $display("FAIL wrap_next got=%b/%h want=1/0", req_v, req_a); end
    mem_auto = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_AAAA;
    step();
    imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
    checks++; if (ivld !== 1'b0 || req_v !== 1'b1 || req_a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL late_resp got=%b/%b/%h want=0/1/fffffffc", ivld, req_v, req_a); end
    step();
    checks++; if (ivld !== 1'b0) begin errors++; $display("FAIL late_resp_after got=%b want=0", ivld); end
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    mem_auto = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_stall();
    test_wrap_late_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
